// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 control unit: state enum, opcodes and
// datapath mux select values.
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        StHalted, St18, St33, St35, St32,
        St01, St05, St09, St00, St22, St12, St04, St21, St20,
        St02, St10, St03, St11, St06, St07,
        St25, St24, St26, St29, St31, St27, St23, St16, St14,
        StPauseIr1, StPauseIr2
    } state_e;

    localparam logic [3:0] OpBr  = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpLd  = 4'b0010;
    localparam logic [3:0] OpSt  = 4'b0011;
    localparam logic [3:0] OpJsr = 4'b0100;
    localparam logic [3:0] OpAnd = 4'b0101;
    localparam logic [3:0] OpLdr = 4'b0110;
    localparam logic [3:0] OpStr = 4'b0111;
    localparam logic [3:0] OpNot = 4'b1001;
    localparam logic [3:0] OpLdi = 4'b1010;
    localparam logic [3:0] OpSti = 4'b1011;
    localparam logic [3:0] OpJmp = 4'b1100;
    localparam logic [3:0] OpRes = 4'b1101;
    localparam logic [3:0] OpLea = 4'b1110;

    localparam logic [1:0] PcMuxInc   = 2'b00;
    localparam logic [1:0] PcMuxBus   = 2'b01;
    localparam logic [1:0] PcMuxAdder = 2'b10;

    localparam logic [1:0] Addr2Zero  = 2'b00;
    localparam logic [1:0] Addr2Off6  = 2'b01;
    localparam logic [1:0] Addr2Off9  = 2'b10;
    localparam logic [1:0] Addr2Off11 = 2'b11;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluAnd   = 2'b01;
    localparam logic [1:0] AluNot   = 2'b10;
    localparam logic [1:0] AluPassA = 2'b11;

    // States that hold an SRAM strobe for MEM_WAIT cycles.
    function automatic logic is_mem_state(state_e s);
        return (s == St33) || (s == St25) || (s == St24) || (s == St29) || (s == St16);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Dwell counter for SRAM accesses: cleared on entry to a memory state, counts
// while the FSM sits in it, and flags the final dwell cycle.
module mem_wait_timer #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic en,
    output logic done
);
    localparam int unsigned CntW = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(MEM_WAIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign done = en && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (en && !done) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lc3_isdu_ws.sv
// LC-3 instruction sequencer: Moore control FSM driving datapath loads, bus gates,
// mux selects and SRAM strobes, with parametrised memory wait states.
module lc3_isdu_ws
    import lc3_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2,
    parameter bit          PAUSE_EN = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic       Illegal
);
    state_e state_q, state_d;
    logic   in_mem, mem_start, mem_done;

    assign Mem_CE = 1'b0;
    assign Mem_UB = 1'b0;
    assign Mem_LB = 1'b0;

    assign in_mem    = is_mem_state(state_q);
    // Reload on every fresh entry, including back-to-back accesses.
    assign mem_start = is_mem_state(state_d) && (!in_mem || mem_done);

    mem_wait_timer #(
        .MEM_WAIT(MEM_WAIT)
    ) u_timer (
        .clk  (Clk),
        .rst_n(Reset_n),
        .start(mem_start),
        .en   (in_mem),
        .done (mem_done)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StHalted;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PcMuxInc;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = Addr2Zero;
        ALUK       = AluAdd;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        Illegal    = 1'b0;

        case (state_q)
            StHalted: if (Run) state_d = St18;
            St18: begin
                LD_MAR  = 1'b1;
                GatePC  = 1'b1;
                LD_PC   = 1'b1;
                state_d = St33;
            end
            St33, St25, St24, St29: begin
                Mem_OE = 1'b0;
                LD_MDR = mem_done;
                if (mem_done) begin
                    case (state_q)
                        St33:    state_d = St35;
                        St25:    state_d = St27;
                        St24:    state_d = St26;
                        default: state_d = St31;
                    endcase
                end
            end
            St16: begin
                Mem_WE = 1'b0;
                if (mem_done) state_d = St18;
            end
            St35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                state_d = St32;
            end
            St32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    OpAdd: state_d = St01;
                    OpAnd: state_d = St05;
                    OpNot: state_d = St09;
                    OpBr:  state_d = St00;
                    OpJmp: state_d = St12;
                    OpJsr: state_d = St04;
                    OpLd:  state_d = St02;
                    OpLdi: state_d = St10;
                    OpLdr: state_d = St06;
                    OpLea: state_d = St14;
                    OpSt:  state_d = St03;
                    OpSti: state_d = St11;
                    OpStr: state_d = St07;
                    OpRes: begin
                        if (PAUSE_EN) begin
                            state_d = StPauseIr1;
                        end else begin
                            Illegal = 1'b1;
                            state_d = St18;
                        end
                    end
                    default: begin
                        Illegal = 1'b1;
                        state_d = St18;
                    end
                endcase
            end
            St01, St05, St09: begin
                SR1MUX  = 1'b1;
                SR2MUX  = (state_q != St09) && IR_5;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                ALUK    = (state_q == St01) ? AluAdd : (state_q == St05) ? AluAnd : AluNot;
                state_d = St18;
            end
            St00: state_d = BEN ? St22 : St18;
            St22, St21: begin
                LD_PC    = 1'b1;
                PCMUX    = PcMuxAdder;
                ADDR2MUX = (state_q == St22) ? Addr2Off9 : Addr2Off11;
                state_d  = St18;
            end
            St12, St20: begin
                LD_PC    = 1'b1;
                PCMUX    = PcMuxAdder;
                ADDR1MUX = 1'b1;
                SR1MUX   = 1'b1;
                state_d  = St18;
            end
            St04: begin
                DRMUX   = 1'b1;
                GatePC  = 1'b1;
                LD_REG  = 1'b1;
                state_d = IR_11 ? St21 : St20;
            end
            St02, St10, St03, St11: begin
                LD_MAR     = 1'b1;
                GateMARMUX = 1'b1;
                ADDR2MUX   = Addr2Off9;
                case (state_q)
                    St02:    state_d = St25;
                    St10:    state_d = St24;
                    St03:    state_d = St23;
                    default: state_d = St29;
                endcase
            end
            St06, St07: begin
                LD_MAR     = 1'b1;
                GateMARMUX = 1'b1;
                ADDR1MUX   = 1'b1;
                SR1MUX     = 1'b1;
                ADDR2MUX   = Addr2Off6;
                state_d    = (state_q == St06) ? St25 : St23;
            end
            St26, St31: begin
                LD_MAR  = 1'b1;
                GateMDR = 1'b1;
                state_d = (state_q == St26) ? St25 : St23;
            end
            St27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = St18;
            end
            St23: begin
                LD_MDR  = 1'b1;
                GateALU = 1'b1;
                ALUK    = AluPassA;
                state_d = St16;
            end
            St14: begin
                GateMARMUX = 1'b1;
                LD_REG     = 1'b1;
                ADDR2MUX   = Addr2Off9;
                state_d    = St18;
            end
            StPauseIr1: begin
                LD_LED = 1'b1;
                if (Continue) state_d = StPauseIr2;
            end
            StPauseIr2: if (!Continue) state_d = St18;
            default: state_d = StHalted;
        endcase
    end

endmodule

// File: tb/tb_lc3_isdu_ws.sv
// Bench for lc3_isdu_ws: three configurations checked with a directed vector table,
// hand-written pause/reset sequences and random instructions against a micro-step model.
module tb_lc3_isdu_ws;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux, aluk;
        logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we, illegal;
    } ctrl_t;

    typedef struct {
        int         g;
        logic [3:0] op;
        logic       ir5, ir11, ben;
        int         cyc, ill, ldpc, oe, we;
    } vec_t;

    logic       Clk;
    logic [2:0] rst_n_v;
    logic       Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    ctrl_t      ctrl [3];
    ctrl_t      exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cur = -1;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Instance 0: MEM_WAIT=3, instance 1: MEM_WAIT=1, instance 2: MEM_WAIT=2 without PAUSE.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 3 : ((g == 1) ? 1 : 2);
        localparam bit          P = (g != 2);
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we, illegal;

        lc3_isdu_ws #(.MEM_WAIT(W), .PAUSE_EN(P)) u_dut (
            .Clk(Clk), .Reset_n(rst_n_v[g]), .Run(Run), .Continue(Continue),
            .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
            .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
            .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
            .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu),
            .GateMARMUX(gate_marmux), .PCMUX(pcmux), .DRMUX(drmux), .SR1MUX(sr1mux),
            .SR2MUX(sr2mux), .ADDR1MUX(addr1mux), .ADDR2MUX(addr2mux), .ALUK(aluk),
            .Mem_CE(mem_ce), .Mem_UB(mem_ub), .Mem_LB(mem_lb), .Mem_OE(mem_oe),
            .Mem_WE(mem_we), .Illegal(illegal)
        );

        assign ctrl[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                          gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux, drmux, sr1mux,
                          sr2mux, addr1mux, addr2mux, aluk, mem_ce, mem_ub, mem_lb, mem_oe,
                          mem_we, illegal};
    end

    function automatic int cfg_wait(int g);
        return (g == 0) ? 3 : ((g == 1) ? 1 : 2);
    endfunction

    function automatic bit cfg_pause(int g);
        return g != 2;
    endfunction

    function automatic ctrl_t idle_w();
        ctrl_t c;
        c = '0;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t fetch_w();
        ctrl_t c;
        c = idle_w();
        c.ld_mar = 1'b1; c.gate_pc = 1'b1; c.ld_pc = 1'b1;
        return c;
    endfunction

    function automatic void push_mem(int n, bit wr);
        ctrl_t c;
        for (int i = 0; i < n; i++) begin
            c = idle_w();
            if (wr) c.mem_we = 1'b0;
            else begin
                c.mem_oe = 1'b0;
                c.ld_mdr = (i == n - 1);
            end
            exp_q.push_back(c);
        end
    endfunction

    // Micro-step model: expected control word for every cycle of one instruction,
    // from its fetch up to (not including) the next fetch.
    function automatic void model_instr(int g, logic [3:0] op, logic ir5, logic ir11, logic ben);
        int    mw;
        ctrl_t c, mar_off9, mar_base, mar_mdr, dr_mdr, mdr_sr;
        mw = cfg_wait(g);
        mar_off9 = idle_w();
        mar_off9.ld_mar = 1'b1; mar_off9.gate_marmux = 1'b1; mar_off9.addr2mux = 2'b10;
        mar_base = idle_w();
        mar_base.ld_mar = 1'b1; mar_base.gate_marmux = 1'b1; mar_base.addr1mux = 1'b1;
        mar_base.sr1mux = 1'b1; mar_base.addr2mux = 2'b01;
        mar_mdr = idle_w();
        mar_mdr.ld_mar = 1'b1; mar_mdr.gate_mdr = 1'b1;
        dr_mdr = idle_w();
        dr_mdr.gate_mdr = 1'b1; dr_mdr.ld_reg = 1'b1; dr_mdr.ld_cc = 1'b1;
        mdr_sr = idle_w();
        mdr_sr.ld_mdr = 1'b1; mdr_sr.gate_alu = 1'b1; mdr_sr.aluk = 2'b11;

        exp_q.push_back(fetch_w());
        push_mem(mw, 1'b0);
        c = idle_w(); c.gate_mdr = 1'b1; c.ld_ir = 1'b1;
        exp_q.push_back(c);
        c = idle_w(); c.ld_ben = 1'b1;
        c.illegal = (op == 4'b1000) || (op == 4'b1111) || (op == 4'b1101 && !cfg_pause(g));
        exp_q.push_back(c);

        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                c = idle_w();
                c.sr1mux = 1'b1; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                c.aluk = (op == 4'b0001) ? 2'b00 : ((op == 4'b0101) ? 2'b01 : 2'b10);
                c.sr2mux = (op != 4'b1001) && ir5;
                exp_q.push_back(c);
            end
            4'b0000: begin
                exp_q.push_back(idle_w());
                if (ben) begin
                    c = idle_w(); c.ld_pc = 1'b1; c.pcmux = 2'b10; c.addr2mux = 2'b10;
                    exp_q.push_back(c);
                end
            end
            4'b1100: begin
                c = idle_w(); c.ld_pc = 1'b1; c.pcmux = 2'b10; c.addr1mux = 1'b1; c.sr1mux = 1'b1;
                exp_q.push_back(c);
            end
            4'b0100: begin
                c = idle_w(); c.drmux = 1'b1; c.gate_pc = 1'b1; c.ld_reg = 1'b1;
                exp_q.push_back(c);
                c = idle_w(); c.ld_pc = 1'b1; c.pcmux = 2'b10;
                if (ir11) c.addr2mux = 2'b11;
                else begin
                    c.addr1mux = 1'b1; c.sr1mux = 1'b1;
                end
                exp_q.push_back(c);
            end
            4'b0010: begin exp_q.push_back(mar_off9); push_mem(mw, 1'b0); exp_q.push_back(dr_mdr); end
            4'b0110: begin exp_q.push_back(mar_base); push_mem(mw, 1'b0); exp_q.push_back(dr_mdr); end
            4'b1010: begin
                exp_q.push_back(mar_off9); push_mem(mw, 1'b0);
                exp_q.push_back(mar_mdr);  push_mem(mw, 1'b0);
                exp_q.push_back(dr_mdr);
            end
            4'b0011: begin exp_q.push_back(mar_off9); exp_q.push_back(mdr_sr); push_mem(mw, 1'b1); end
            4'b0111: begin exp_q.push_back(mar_base); exp_q.push_back(mdr_sr); push_mem(mw, 1'b1); end
            4'b1011: begin
                exp_q.push_back(mar_off9); push_mem(mw, 1'b0);
                exp_q.push_back(mar_mdr);  exp_q.push_back(mdr_sr); push_mem(mw, 1'b1);
            end
            4'b1110: begin
                c = idle_w(); c.gate_marmux = 1'b1; c.ld_reg = 1'b1; c.addr2mux = 2'b10;
                exp_q.push_back(c);
            end
            default: ;
        endcase
    endfunction

    task automatic chk_ctrl(string name, ctrl_t act, ctrl_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %07h want %07h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reset config g (others held in reset) and step it from Halted into its first fetch.
    task automatic start_cfg(int g);
        cur = g;
        rst_n_v = 3'b000; Run = 1'b1; Continue = 1'b0;
        Opcode = 4'b0000; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        repeat (2) @(negedge Clk);
        #1 chk_ctrl($sformatf("reset_cfg%0d", g), ctrl[g], idle_w());
        Run = 1'b0;
        rst_n_v[g] = 1'b1;
        @(negedge Clk); #1;
        chk_ctrl($sformatf("halted_cfg%0d", g), ctrl[g], idle_w());
        Run = 1'b1;
        @(negedge Clk); #1;
        chk_ctrl($sformatf("run_fetch_cfg%0d", g), ctrl[g], fetch_w());
    endtask

    task automatic check_q(string name);
        ctrl_t e;
        int    k;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_ctrl($sformatf("%s[%0d]", name, k), ctrl[cur], e);
            k++;
            @(negedge Clk); #1;
        end
    endtask

    task automatic run_vec(int idx, vec_t v);
        int cyc, ill, ldpc, oe, we;
        bit found;
        cyc = 0; ill = 0; ldpc = 0; oe = 0; we = 0; found = 1'b0;
        Opcode = v.op; IR_5 = v.ir5; IR_11 = v.ir11; BEN = v.ben;
        Continue = 1'b0; Run = 1'($urandom);
        for (int i = 0; i < 64; i++) begin
            cyc++;
            ill  += int'(ctrl[cur].illegal);
            ldpc += int'(ctrl[cur].ld_pc);
            oe   += int'(!ctrl[cur].mem_oe);
            we   += int'(!ctrl[cur].mem_we);
            @(negedge Clk); #1;
            if (ctrl[cur].ld_mar && ctrl[cur].gate_pc) begin
                found = 1'b1;
                break;
            end
        end
        chk_int($sformatf("vec%0d_refetch", idx), int'(found), 1);
        chk_int($sformatf("vec%0d_cycles", idx), cyc, v.cyc);
        chk_int($sformatf("vec%0d_illegal", idx), ill, v.ill);
        chk_int($sformatf("vec%0d_ldpc", idx), ldpc, v.ldpc);
        chk_int($sformatf("vec%0d_oe_low", idx), oe, v.oe);
        chk_int($sformatf("vec%0d_we_low", idx), we, v.we);
    endtask

    task automatic run_instr(string name, logic [3:0] op, logic ir5, logic ir11, logic ben);
        Opcode = op; IR_5 = ir5; IR_11 = ir11; BEN = ben;
        Run = 1'($urandom); Continue = 1'($urandom);
        model_instr(cur, op, ir5, ir11, ben);
        check_q(name);
    endtask

    vec_t  vecs [14];
    ctrl_t led_w, rd_w;

    initial begin
        //       cfg op     ir5 ir11 ben cyc ill ldpc oe we
        vecs[0]  = '{0, 4'h1, 1, 0, 0,  7, 0, 1, 3, 0};
        vecs[1]  = '{0, 4'hA, 0, 0, 0, 15, 0, 1, 9, 0};
        vecs[2]  = '{0, 4'h4, 0, 1, 0,  8, 0, 2, 3, 0};
        vecs[3]  = '{1, 4'h7, 0, 0, 0,  7, 0, 1, 1, 1};
        vecs[4]  = '{1, 4'h0, 0, 0, 0,  5, 0, 1, 1, 0};
        vecs[5]  = '{1, 4'h0, 0, 0, 1,  6, 0, 2, 1, 0};
        vecs[6]  = '{1, 4'h4, 0, 0, 0,  6, 0, 2, 1, 0};
        vecs[7]  = '{1, 4'h8, 0, 0, 0,  4, 1, 1, 1, 0};
        vecs[8]  = '{1, 4'hC, 0, 0, 0,  5, 0, 2, 1, 0};
        vecs[9]  = '{2, 4'hD, 0, 0, 0,  5, 1, 1, 2, 0};
        vecs[10] = '{2, 4'hE, 0, 0, 0,  6, 0, 1, 2, 0};
        vecs[11] = '{2, 4'hB, 0, 0, 0, 12, 0, 1, 4, 2};
        vecs[12] = '{2, 4'h6, 0, 0, 0,  9, 0, 1, 4, 0};
        vecs[13] = '{2, 4'hF, 0, 0, 0,  5, 1, 1, 2, 0};

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].g != cur) start_cfg(vecs[i].g);
            run_vec(i, vecs[i]);
        end

        // Reset asserted in the middle of a read dwell drops OE without a clock edge.
        start_cfg(0);
        Run = 1'b0; Continue = 1'b0;
        Opcode = 4'b0010; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        model_instr(0, 4'b0010, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 7) exp_q.delete(exp_q.size() - 1);
        check_q("ld_pre_reset");
        rd_w = idle_w(); rd_w.mem_oe = 1'b0;
        chk_ctrl("s25_oe_low", ctrl[0], rd_w);
        #2 rst_n_v[0] = 1'b0;
        #1 chk_ctrl("reset_ends_strobe", ctrl[0], idle_w());
        @(negedge Clk); #1;
        chk_ctrl("reset_held_idle", ctrl[0], idle_w());

        // Pause with a press after entry, held for two cycles.
        start_cfg(0);
        led_w = idle_w(); led_w.ld_led = 1'b1;
        Opcode = 4'b1101; Continue = 1'b0; Run = 1'($urandom);
        model_instr(0, 4'b1101, 1'b0, 1'b0, 1'b0);
        check_q("pauseA");
        chk_ctrl("pauseA_led0", ctrl[0], led_w);
        @(negedge Clk); #1;
        chk_ctrl("pauseA_led1", ctrl[0], led_w);
        Continue = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk); #1;
            chk_ctrl($sformatf("pauseA_hold%0d", i), ctrl[0], idle_w());
        end
        Continue = 1'b0;
        @(negedge Clk); #1;
        chk_ctrl("pauseA_resume", ctrl[0], fetch_w());

        // Continue already high on entry: one instruction per press.
        Continue = 1'b1;
        model_instr(0, 4'b1101, 1'b0, 1'b0, 1'b0);
        check_q("pauseB");
        chk_ctrl("pauseB_led", ctrl[0], led_w);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk); #1;
            chk_ctrl($sformatf("pauseB_hold%0d", i), ctrl[0], idle_w());
        end
        Continue = 1'b0;
        @(negedge Clk); #1;
        chk_ctrl("pauseB_resume", ctrl[0], fetch_w());

        for (int g = 0; g < 3; g++) begin
            start_cfg(g);
            for (int n = 0; n < 40; n++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 15));
                if (op == 4'b1101 && cfg_pause(g)) op = 4'b0001;
                run_instr($sformatf("rnd_cfg%0d_n%0d_op%0h", g, n, op), op, 1'($urandom),
                          1'($urandom), 1'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
